// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the immediate-extension pipeline.
//   - ext_mode_e : mode encodings (ZERO, SIGN, UPPER, BRANCH, JUMP; 5-7 reserved)
//   - EXT_MODE_W : width of the mode field
//   - EXT_MAX_W  : widest datapath ext_calc can serve
//   - ext_calc() : pure extension function, widths passed as arguments so one
//                  body serves every parameterisation of the pipeline
package ext_pkg;

  localparam int EXT_MODE_W = 3;
  localparam int EXT_MAX_W  = 64;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_ZERO   = 3'd0,
    EXT_SIGN   = 3'd1,
    EXT_UPPER  = 3'd2,
    EXT_BRANCH = 3'd3,
    EXT_JUMP   = 3'd4
  } ext_mode_e;

  // Inputs arrive zero-extended to EXT_MAX_W; the result is truncated to data_w.
  function automatic logic [EXT_MAX_W-1:0] ext_calc(
    input logic [EXT_MODE_W-1:0] mode,
    input logic [EXT_MAX_W-1:0]  imm,
    input logic [EXT_MAX_W-1:0]  jidx,
    input logic [EXT_MAX_W-1:0]  pc4,
    input int                    data_w,
    input int                    imm_w,
    input int                    jidx_w
  );
    logic [EXT_MAX_W-1:0] one;
    logic [EXT_MAX_W-1:0] imm_m;
    logic [EXT_MAX_W-1:0] jidx_m;
    logic [EXT_MAX_W-1:0] keep_m;
    logic [EXT_MAX_W-1:0] data_m;
    logic [EXT_MAX_W-1:0] zx;
    logic [EXT_MAX_W-1:0] sx;
    logic [EXT_MAX_W-1:0] res;
    logic                 sbit;
    one    = 1;
    imm_m  = (one << imm_w) - one;
    jidx_m = (one << jidx_w) - one;
    keep_m = (one << (jidx_w + 2)) - one;
    // A shift of EXT_MAX_W yields 0, so 0 - 1 gives the all-ones mask.
    data_m = (one << data_w) - one;
    zx     = imm & imm_m;
    // Sign bit isolated as the top bit of the immediate mask.
    sbit   = |(zx & (imm_m ^ (imm_m >> 1)));
    sx     = sbit ? (zx | ~imm_m) : zx;
    case (mode)
      EXT_SIGN:   res = sx;
      EXT_UPPER:  res = zx << (data_w - imm_w);
      EXT_BRANCH: res = sx << 2;
      EXT_JUMP:   res = (pc4 & ~keep_m) | ((jidx & jidx_m) << 2);
      default:    res = zx;
    endcase
    return res & data_m;
  endfunction

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational stage-1 immediate extension.
// Ports:
//   mode_i      - extension mode (ext_mode_e encoding)
//   imm_i       - raw immediate
//   jidx_i      - jump index field
//   pc4_i       - PC+4, supplies the region bits for JUMP
//   ext_o       - extended value
//   is_branch_o - mode is BRANCH
//   is_jump_o   - mode is JUMP
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26
) (
  input  logic [EXT_MODE_W-1:0] mode_i,
  input  logic [IMM_W-1:0]      imm_i,
  input  logic [JIDX_W-1:0]     jidx_i,
  input  logic [DATA_W-1:0]     pc4_i,
  output logic [DATA_W-1:0]     ext_o,
  output logic                  is_branch_o,
  output logic                  is_jump_o
);

  logic [EXT_MAX_W-1:0] ext_full;
  logic                 unused_ext_par;

  assign ext_full = ext_calc(mode_i, EXT_MAX_W'(imm_i), EXT_MAX_W'(jidx_i),
                             EXT_MAX_W'(pc4_i), DATA_W, IMM_W, JIDX_W);

  // ext_calc already zeroes everything above DATA_W.
  assign ext_o          = ext_full[DATA_W-1:0];
  assign unused_ext_par = ^ext_full;

  assign is_branch_o = (mode_i == EXT_BRANCH);
  assign is_jump_o   = (mode_i == EXT_JUMP);

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage valid/ready immediate-extension and control-target
// pipeline for the decode/execute boundary.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   in_valid/ready   - request handshake (in_ready is combinational)
//   in_mode          - ZERO/SIGN/UPPER/BRANCH/JUMP, 5-7 treated as ZERO
//   in_imm, in_jidx  - raw immediate and jump index
//   in_pc4           - PC+4 of the instruction
//   flush            - drop every in-flight entry on the next edge
//   out_valid/ready  - result handshake
//   out_ext          - extended immediate
//   out_target       - branch/jump target, 0 for non-control modes
//   out_is_ctrl      - mode was BRANCH or JUMP
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [JIDX_W-1:0]     in_jidx,
  input  logic [DATA_W-1:0]     in_pc4,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_ext,
  output logic [DATA_W-1:0]     out_target,
  output logic                  out_is_ctrl
);

  logic [DATA_W-1:0] ext_d;
  logic              br_d;
  logic              jmp_d;

  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_ext_q;
  logic [DATA_W-1:0] s1_pc4_q;
  logic              s1_br_q;
  logic              s1_jmp_q;

  logic              s2_vld_q, s2_vld_d;
  logic [DATA_W-1:0] s2_ext_q;
  logic [DATA_W-1:0] s2_tgt_q;
  logic              s2_ctrl_q;
  logic [DATA_W-1:0] tgt_d;

  logic s2_adv, s1_adv, in_xfer, s1_load, s2_load;

  // Stage 1: extension
  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .JIDX_W (JIDX_W)
  ) u_core (
    .mode_i      (in_mode),
    .imm_i       (in_imm),
    .jidx_i      (in_jidx),
    .pc4_i       (in_pc4),
    .ext_o       (ext_d),
    .is_branch_o (br_d),
    .is_jump_o   (jmp_d)
  );

  // No skid buffer: in_ready follows out_ready combinationally.
  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = s1_vld_q && s2_adv;
  assign in_ready = !s1_vld_q || s1_adv;
  assign in_xfer  = in_valid && in_ready;
  // Flush outranks every transfer, so nothing loads in a flush cycle.
  assign s1_load  = in_xfer && !flush;
  assign s2_load  = s1_adv && !flush;

  always_comb begin
    s1_vld_d = s1_vld_q;
    if (flush)        s1_vld_d = 1'b0;
    else if (in_xfer) s1_vld_d = 1'b1;
    else if (s1_adv)  s1_vld_d = 1'b0;
  end

  always_comb begin
    s2_vld_d = s2_vld_q;
    if (flush)       s2_vld_d = 1'b0;
    else if (s2_adv) s2_vld_d = s1_vld_q;
  end

  // Stage 2: target resolution, wraps modulo 2^DATA_W
  always_comb begin
    tgt_d = '0;
    if (s1_br_q)       tgt_d = s1_pc4_q + s1_ext_q;
    else if (s1_jmp_q) tgt_d = s1_ext_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_ext_q  <= '0;
      s1_pc4_q  <= '0;
      s1_br_q   <= 1'b0;
      s1_jmp_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_ext_q  <= '0;
      s2_tgt_q  <= '0;
      s2_ctrl_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (s1_load) begin
        s1_ext_q <= ext_d;
        s1_pc4_q <= in_pc4;
        s1_br_q  <= br_d;
        s1_jmp_q <= jmp_d;
      end
      if (s2_load) begin
        s2_ext_q  <= s1_ext_q;
        s2_tgt_q  <= tgt_d;
        s2_ctrl_q <= s1_br_q || s1_jmp_q;
      end
    end
  end

  assign out_valid   = s2_vld_q;
  assign out_ext     = s2_ext_q;
  assign out_target  = s2_tgt_q;
  assign out_is_ctrl = s2_ctrl_q;

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate-extension and control-target unit for the decode/execute boundary of the pipelined MIPS core. It widens a raw immediate under one of five modes: zero, sign, upper, branch-offset or jump-index. It also produces the resolved branch/jump target from the incoming PC+4. The result flows through a two-stage valid/ready pipeline with flush support, so it can absorb execute-stage stalls.

## Interface
- DATA_W, 32, result/PC width; must satisfy DATA_W >= IMM_W+2 and DATA_W >= JIDX_W+2
- IMM_W, 16, raw immediate width
- JIDX_W, 26, jump index width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  request present
- in_ready  out  1  stage 1 can accept
- in_mode  in  3  0 ZERO, 1 SIGN, 2 UPPER, 3 BRANCH, 4 JUMP; 5–7 reserved
- in_imm  in  IMM_W  raw immediate
- in_jidx  in  JIDX_W  jump index field
- in_pc4  in  DATA_W  PC+4 of the instruction
- flush  in  1  kill all in-flight entries
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_ext  out  DATA_W  extended immediate
- out_target  out  DATA_W  control target; 0 for non-control modes
- out_is_ctrl  out  1  mode was BRANCH or JUMP

## Operation
- Extension, computed in stage 1:
  - ZERO: zero-extend in_imm.
  - SIGN: replicate in_imm[IMM_W-1].
  - UPPER: in_imm placed at the top IMM_W bits, low bits 0.
  - BRANCH: sign-extend, then shift left 2 with wrap truncated to DATA_W.
  - JUMP: {in_pc4[DATA_W-1:JIDX_W+2], in_jidx, 2'b00}.
  - Reserved modes behave as ZERO with is_ctrl=0.
- Stage 1 registers ext, mode class, pc4 and valid (s1).
- Target, computed in stage 2:
  - BRANCH: pc4 + ext, modulo 2^DATA_W.
  - JUMP: ext.
  - Other modes: 0.
- Stage 2 registers ext, target, is_ctrl and valid (s2), which drive the outputs directly.
- Handshake:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid and s2 advances.
  - in_ready = !s1_valid || s1 advances. This is combinational from out_ready; no skid buffer.
  - Transfer occurs only when valid && ready in the same cycle.
- Payload registers load only on transfer. Stalled entries hold every output bit stable.
- Flush:
  - Synchronous. On the next edge s1_valid and s2_valid become 0.
  - An input presented in the flush cycle is dropped; in_ready stays per the normal rule.
  - Flush has priority over every transfer in the same cycle.
- Reset: s1_valid = s2_valid = 0. out_ext, out_target and out_is_ctrl reset to 0, and all payload registers are cleared.
- Reset asserted mid-stream discards all entries; there is no replay.

## Timing
- Latency: 2 cycles from input transfer to out_valid with no backpressure.
- Throughput: 1 per cycle.
- Capacity: 2 entries. With out_ready held low, in_ready falls after two accepted requests.
- Simultaneous pop and push when full: both occur in the same cycle and occupancy is unchanged.
- out_valid, out_ext, out_target and out_is_ctrl are registered; in_ready is the only combinational output.

## Structure
- Shared package ext_pkg holds:
  - the mode encodings (EXT_ZERO..EXT_JUMP);
  - the mode-width constant EXT_MODE_W = 3;
  - a pure function ext_calc(mode, imm, jidx, pc4) used by both RTL and the bench model.
- One sub-module, ext_core, contains the combinational stage-1 extension. It is the direct successor of the current extension unit.
- The stage-2 adder and handshake logic stay in imm_ext_pipe.

## Test plan
- SIGN, imm 0xFFFC, out_ready=1 -> after 2 cycles out_ext=0xFFFFFFFC, out_target=0, out_is_ctrl=0.
- BRANCH, imm 0xFFFF, pc4 0x00400004 -> out_ext=0xFFFFFFFC, out_target=0x00400000, out_is_ctrl=1; imm 0x0003 -> target 0x00400010.
- UPPER imm 0x1234 -> 0x12340000. JUMP jidx 0x0100000, pc4 0x80000004 -> out_ext=out_target=0x80400000. ZERO imm 0x8001 -> 0x00008001.
- Backpressure: out_ready=0, stream 3 requests -> 2 accepted, in_ready=0, outputs stable. Then out_ready=1 -> all 3 delivered in order, no loss or duplication.
- Flush with 2 entries in flight plus in_valid=1 the same cycle -> next cycle out_valid=0, no stale results emerge, and the next request returns after 2 cycles.
- Assert rst_n low mid-stream asynchronously -> all outputs 0 immediately. Release -> first new request appears after exactly 2 cycles.
